// File: rtl/adc_spi_ctrl.sv
// rtl/adc_spi_ctrl.sv - periodic SPI frame engine for a 12-bit, 8-channel serial ADC
// Sends a 6-bit config word per frame and holds the last 12-bit result for the processor.
module adc_spi_ctrl #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [2:0]  channel,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_mosi,
    input  logic        adc_miso,
    output logic [11:0] adc_value,
    output logic        valid,
    output logic        busy
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int DW = $clog2(2 * CLK_DIV) + 1;

    localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] HALF      = DW'(CLK_DIV);
    localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] BIT_LAST  = DW'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] per_cnt;
    logic          tick;
    logic          pending, pending_n;
    logic          start;
    logic [DW-1:0] div, div_n;
    logic [3:0]    bit_idx, bit_n;
    logic [2:0]    ch_r, ch_n;
    logic [15:0]   shift_r, shift_n;
    logic [11:0]   value_r, value_n;
    logic          valid_n;
    logic          cs_n_n, sclk_n, mosi_n, busy_n;

    // Config word {1, ch[2:0], 2'b10} sent MSB first; bits past the sixth are zero.
    function automatic logic cfg_bit(input logic [2:0] ch, input logic [3:0] idx);
        logic [5:0] cfg;
        cfg = {1'b1, ch, 2'b10};
        if (idx < 4'd6)
            return cfg[3'd5 - idx[2:0]];
        return 1'b0;
    endfunction

    assign tick = (per_cnt == PER_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            per_cnt <= '0;
        else if (tick)
            per_cnt <= '0;
        else
            per_cnt <= per_cnt + 1'b1;
    end

    always_comb begin
        state_n = state;
        div_n   = div;
        bit_n   = bit_idx;
        ch_n    = ch_r;
        shift_n = shift_r;
        value_n = value_r;
        valid_n = 1'b0;
        start   = enable && (pending || tick);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_SETUP;
                    div_n   = '0;
                    ch_n    = channel;
                end
            end
            S_SETUP: begin
                if (div == HALF_LAST) begin
                    state_n = S_SHIFT;
                    div_n   = '0;
                    bit_n   = '0;
                end else begin
                    div_n = div + 1'b1;
                end
            end
            S_SHIFT: begin
                // MISO is taken on the last clk of the high phase, just before SCLK falls.
                if (div == BIT_LAST) begin
                    shift_n = {shift_r[14:0], adc_miso};
                    div_n   = '0;
                    if (bit_idx == 4'd15)
                        state_n = S_HOLD;
                    else
                        bit_n = bit_idx + 1'b1;
                end else begin
                    div_n = div + 1'b1;
                end
            end
            S_HOLD: begin
                if (div == HALF_LAST) begin
                    state_n = S_IDLE;
                    value_n = shift_r[15:4];
                    valid_n = 1'b1;
                end else begin
                    div_n = div + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (!enable)
            pending_n = 1'b0;
        else if (state == S_IDLE && start)
            pending_n = 1'b0;
        else if (tick)
            pending_n = 1'b1;
        else
            pending_n = pending;

        // Pin values are registered from the next state so the SPI lines never glitch.
        cs_n_n = !(state_n == S_SETUP || state_n == S_SHIFT);
        sclk_n = (state_n == S_SHIFT) && (div_n >= HALF);
        busy_n = (state_n != S_IDLE);
        if (state_n == S_SETUP)
            mosi_n = 1'b1;
        else if (state_n == S_SHIFT)
            mosi_n = cfg_bit(ch_n, bit_n);
        else
            mosi_n = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            pending  <= 1'b0;
            div      <= '0;
            bit_idx  <= '0;
            ch_r     <= '0;
            shift_r  <= '0;
            value_r  <= '0;
            valid    <= 1'b0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            adc_mosi <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            div      <= div_n;
            bit_idx  <= bit_n;
            ch_r     <= ch_n;
            shift_r  <= shift_n;
            value_r  <= value_n;
            valid    <= valid_n;
            adc_cs_n <= cs_n_n;
            adc_sclk <= sclk_n;
            adc_mosi <= mosi_n;
            busy     <= busy_n;
        end
    end

    assign adc_value = value_r;

endmodule

// File: tb/tb_adc_spi_ctrl.sv
// tb/tb_adc_spi_ctrl.sv - directed self-checking bench for adc_spi_ctrl
// Main instance uses default timing; a second instance with a short period covers back-to-back frames.
module tb_adc_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  channel = 3'd0;
    logic        adc_miso = 1'b0;
    logic        adc_cs_n, adc_sclk, adc_mosi, valid, busy;
    logic [11:0] adc_value;

    logic        enable_b = 1'b0;
    logic        miso_b = 1'b1;
    logic        cs_n_b, sclk_b, mosi_b, valid_b, busy_b;
    logic [11:0] value_b;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adc_spi_ctrl #(.CLK_DIV(4), .SAMPLE_PERIOD(5000)) dut (
        .clk(clk), .reset_n(rst_n), .enable(enable), .channel(channel),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_mosi(adc_mosi), .adc_miso(adc_miso),
        .adc_value(adc_value), .valid(valid), .busy(busy)
    );

    adc_spi_ctrl #(.CLK_DIV(4), .SAMPLE_PERIOD(100)) dut_b (
        .clk(clk), .reset_n(rst_n), .enable(enable_b), .channel(3'd2),
        .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .adc_mosi(mosi_b), .adc_miso(miso_b),
        .adc_value(value_b), .valid(valid_b), .busy(busy_b)
    );

    // ADC model: presents word[15] when CS falls, advances one bit on each SCLK fall.
    logic [15:0] adc_word = 16'hABC0;
    int          miso_ptr = 0;
    logic        m_prev_cs = 1'b1;
    logic        m_prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (m_prev_cs && !adc_cs_n)
            miso_ptr = 0;
        else if (!adc_cs_n && m_prev_sclk && !adc_sclk && miso_ptr < 15)
            miso_ptr = miso_ptr + 1;
        m_prev_cs   = adc_cs_n;
        m_prev_sclk = adc_sclk;
        adc_miso    = adc_cs_n ? 1'b0 : adc_word[15 - miso_ptr];
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for CS to fall, then follows the frame until valid; lat = cycles from CS low to valid.
    task automatic capture_frame(input int chg_at, input logic [2:0] new_ch, input int dis_at,
                                 output int lat, output int rises, output logic [15:0] mosi_cap);
        logic started;
        logic prev;
        started  = 1'b0;
        lat      = -1;
        rises    = 0;
        mosi_cap = '0;
        for (int n = 0; n < 6000 && !started; n++) begin
            if (!adc_cs_n) started = 1'b1;
            else step();
        end
        if (!started) return;
        prev = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k == chg_at) channel = new_ch;
            if (k == dis_at) enable = 1'b0;
            if (!adc_cs_n && adc_sclk && !prev) begin
                rises++;
                mosi_cap = {mosi_cap[14:0], adc_mosi};
            end
            prev = adc_sclk;
            if (valid) begin
                lat = k;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        enable  = 1'b1;
        channel = 3'd7;
        enable_b = 1'b1;
        repeat (3) step();
        n_checks++; if (adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); end
        n_checks++; if (adc_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", adc_sclk); end
        n_checks++; if (adc_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", adc_mosi); end
        n_checks++; if (adc_value !== 12'h000) begin n_fail++; $display("FAIL reset_value: got %h expected 000", adc_value); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({cs_n_b, sclk_b, mosi_b, busy_b} !== 4'b1000) begin n_fail++; $display("FAIL reset_b_pins: got %b expected 1000", {cs_n_b, sclk_b, mosi_b, busy_b}); end
        channel = 3'd3;
        rst_n   = 1'b1;
    endtask

    task automatic test_single_conversion();
        int lat, rises;
        logic [15:0] mc;
        adc_word = 16'hABC0;
        capture_frame(-1, 3'd0, -1, lat, rises, mc);
        n_checks++; if (lat !== 136) begin n_fail++; $display("FAIL single_latency: got %0d expected 136", lat); end
        n_checks++; if (rises !== 16) begin n_fail++; $display("FAIL single_sclk_rises: got %0d expected 16", rises); end
        n_checks++; if (mc !== 16'hB800) begin n_fail++; $display("FAIL single_mosi: got %h expected b800", mc); end
        n_checks++; if (adc_value !== 12'hABC) begin n_fail++; $display("FAIL single_value: got %h expected abc", adc_value); end
        step();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_width: got %b expected 0", valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_channel_latch();
        int lat, rises;
        logic [15:0] mc;
        channel  = 3'd3;
        adc_word = 16'h3C50;
        capture_frame(60, 3'd5, -1, lat, rises, mc);
        n_checks++; if (mc !== 16'hB800) begin n_fail++; $display("FAIL latch_cur_mosi: got %h expected b800", mc); end
        n_checks++; if (adc_value !== 12'h3C5) begin n_fail++; $display("FAIL latch_cur_value: got %h expected 3c5", adc_value); end
        capture_frame(-1, 3'd0, -1, lat, rises, mc);
        n_checks++; if (mc !== 16'hD800) begin n_fail++; $display("FAIL latch_next_mosi: got %h expected d800", mc); end
        n_checks++; if (lat !== 136) begin n_fail++; $display("FAIL latch_next_latency: got %0d expected 136", lat); end
    endtask

    task automatic test_result_boundaries();
        int lat, rises;
        logic [15:0] mc;
        adc_word = 16'hFFFF;
        capture_frame(-1, 3'd0, -1, lat, rises, mc);
        n_checks++; if (adc_value !== 12'hFFF) begin n_fail++; $display("FAIL bound_fff: got %h expected fff", adc_value); end
        adc_word = 16'h000F;
        capture_frame(-1, 3'd0, -1, lat, rises, mc);
        n_checks++; if (adc_value !== 12'h000) begin n_fail++; $display("FAIL bound_000: got %h expected 000", adc_value); end
        adc_word = 16'h800F;
        capture_frame(-1, 3'd0, -1, lat, rises, mc);
        n_checks++; if (adc_value !== 12'h800) begin n_fail++; $display("FAIL bound_800: got %h expected 800", adc_value); end
    endtask

    task automatic test_enable_gating();
        int lat, rises, cs_lows, valids;
        logic [15:0] mc;
        enable  = 1'b0;
        cs_lows = 0;
        for (int n = 0; n < 15000; n++) begin
            step();
            if (!adc_cs_n) cs_lows++;
        end
        n_checks++; if (cs_lows !== 0) begin n_fail++; $display("FAIL gate_cs_low_cycles: got %0d expected 0", cs_lows); end
        n_checks++; if (adc_value !== 12'h800) begin n_fail++; $display("FAIL gate_value_hold: got %h expected 800", adc_value); end
        adc_word = 16'h1230;
        enable   = 1'b1;
        capture_frame(-1, 3'd0, 50, lat, rises, mc);
        n_checks++; if (lat !== 136) begin n_fail++; $display("FAIL gate_midframe_latency: got %0d expected 136", lat); end
        n_checks++; if (adc_value !== 12'h123) begin n_fail++; $display("FAIL gate_midframe_value: got %h expected 123", adc_value); end
        cs_lows = 0;
        valids  = 0;
        for (int n = 0; n < 10500; n++) begin
            step();
            if (!adc_cs_n) cs_lows++;
            if (valid) valids++;
        end
        n_checks++; if (cs_lows !== 0) begin n_fail++; $display("FAIL gate_no_more_frames: got %0d expected 0", cs_lows); end
        n_checks++; if (valids !== 0) begin n_fail++; $display("FAIL gate_no_more_valid: got %0d expected 0", valids); end
    endtask

    task automatic test_reset_mid_frame();
        logic started;
        started = 1'b0;
        enable  = 1'b1;
        for (int n = 0; n < 6000 && !started; n++) begin
            if (!adc_cs_n) started = 1'b1;
            else step();
        end
        n_checks++; if (started !== 1'b1) begin n_fail++; $display("FAIL midreset_frame_start: got %b expected 1", started); end
        repeat (40) step();
        rst_n = 1'b0;
        #1;
        n_checks++; if (adc_cs_n !== 1'b1) begin n_fail++; $display("FAIL midreset_cs_n: got %b expected 1", adc_cs_n); end
        n_checks++; if (adc_sclk !== 1'b0) begin n_fail++; $display("FAIL midreset_sclk: got %b expected 0", adc_sclk); end
        n_checks++; if (adc_value !== 12'h000) begin n_fail++; $display("FAIL midreset_value: got %h expected 000", adc_value); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int periods[4];
        int highs_at[4];
        int falls, t_last, highs, valids;
        logic prev;
        falls  = 0;
        t_last = -1;
        highs  = 0;
        valids = 0;
        prev   = cs_n_b;
        for (int i = 0; i < 4; i++) begin periods[i] = -1; highs_at[i] = -1; end
        for (int n = 0; n < 700 && falls < 5; n++) begin
            if (prev && !cs_n_b) begin
                if (falls > 0 && falls <= 4) begin
                    periods[falls-1]  = n - t_last;
                    highs_at[falls-1] = highs;
                end
                falls++;
                t_last = n;
                highs  = 0;
            end
            if (cs_n_b) highs++;
            if (valid_b && falls >= 1 && falls <= 3) valids++;
            prev = cs_n_b;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (periods[i] !== 137) begin n_fail++; $display("FAIL b2b_period[%0d]: got %0d expected 137", i, periods[i]); end
            n_checks++; if (highs_at[i] !== 5) begin n_fail++; $display("FAIL b2b_cs_high[%0d]: got %0d expected 5", i, highs_at[i]); end
        end
        n_checks++; if (valids !== 3) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 3", valids); end
        n_checks++; if (value_b !== 12'hFFF) begin n_fail++; $display("FAIL b2b_value: got %h expected fff", value_b); end
    endtask

    initial begin
        test_reset();
        test_single_conversion();
        test_channel_latch();
        test_result_boundaries();
        test_enable_gating();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
